pc_run_monitor: RTL and testbench

Synthesizable run-control and trace monitor for the single-cycle CPU, for use in sccomp-level benches and on-board debug. It watches the retiring PC and stops the run on any of these events:
- a match against one of NUM_HALT programmable halt addresses;
- a cycle-budget timeout;
- a stuck-PC condition.

It also keeps a circular history of the last HIST_DEPTH retired PCs, readable by index. It generalises a fixed halt-PC/cycle-counter bench check into a parametrised block with multiple halt points, stuck detection and trace capture.

---
 rtl/pc_mon_pkg.sv | 23 ++
 rtl/pc_run_monitor_if.sv | 45 ++++
 rtl/pc_hist_buf.sv | 46 ++++
 rtl/pc_run_monitor.sv | 161 ++++++++++++++++
 tb/tb_pc_run_monitor.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_mon_pkg.sv
// Shared definitions for the PC run monitor.
//   mon_state_t : run-control state encoding (IDLE=0, RUN=1, DONE=2)
//   clog2_min1  : ceil(log2(n)), never less than 1, for index/port widths
package pc_mon_pkg;

    typedef enum logic [1:0] {
        MON_IDLE = 2'd0,
        MON_RUN  = 2'd1,
        MON_DONE = 2'd2
    } mon_state_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/pc_run_monitor_if.sv
// Bus bundle for pc_run_monitor.
//   master : drives start, retiring pc/pc_valid, halt configuration,
//            cycle budget and history read index; observes status.
//   slave  : the monitor itself (status, counters, registered hist_pc).
interface pc_run_monitor_if #(
    parameter int PC_WIDTH   = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int NUM_HALT   = 2,
    parameter int HIST_DEPTH = 8
);
    import pc_mon_pkg::*;

    localparam int IDX_W   = clog2_min1(HIST_DEPTH);
    localparam int WHICH_W = clog2_min1(NUM_HALT);

    logic                         start;
    logic [PC_WIDTH-1:0]          pc;
    logic                         pc_valid;
    logic [NUM_HALT*PC_WIDTH-1:0] halt_pc;
    logic [NUM_HALT-1:0]          halt_en;
    logic [CNT_WIDTH-1:0]         max_cycles;
    logic [IDX_W-1:0]             hist_idx;
    logic [PC_WIDTH-1:0]          hist_pc;
    logic [1:0]                   state;
    logic                         done;
    logic                         halt_hit;
    logic [WHICH_W-1:0]           halt_which;
    logic                         timeout;
    logic                         stuck;
    logic [CNT_WIDTH-1:0]         cycle_cnt;
    logic [CNT_WIDTH-1:0]         retire_cnt;

    modport master (
        output start, pc, pc_valid, halt_pc, halt_en, max_cycles, hist_idx,
        input  hist_pc, state, done, halt_hit, halt_which, timeout, stuck,
               cycle_cnt, retire_cnt
    );

    modport slave (
        input  start, pc, pc_valid, halt_pc, halt_en, max_cycles, hist_idx,
        output hist_pc, state, done, halt_hit, halt_which, timeout, stuck,
               cycle_cnt, retire_cnt
    );

endinterface

// File: rtl/pc_hist_buf.sv
// Circular buffer of the most recently retired PCs.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (same effect as rst)
//   wr_en    : write wr_data at the write pointer and advance it
//   rd_idx   : 0 = most recent entry
//   rd_data  : registered read of entry[(wptr-1-rd_idx) mod HIST_DEPTH]
module pc_hist_buf
    import pc_mon_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int HIST_DEPTH = 8,
    localparam int AW        = clog2_min1(HIST_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [PC_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]       rd_idx,
    output logic [PC_WIDTH-1:0] rd_data
);

    logic [PC_WIDTH-1:0] mem [HIST_DEPTH];
    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rd_ptr;

    // Power-of-two depth: modulo wrap falls out of the pointer width.
    assign rd_ptr = wptr - AW'(1) - rd_idx;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr    <= '0;
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_ptr];
            if (wr_en) begin
                mem[wptr] <= wr_data;
                wptr      <= wptr + AW'(1);
            end
        end
    end

endmodule

// File: rtl/pc_run_monitor.sv
// Run-control and trace monitor for the single-cycle CPU.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of pc_run_monitor_if (start, retiring pc,
//              halt comparators, cycle budget, history read, status)
// Stops the run on a halt-PC match, cycle-budget expiry or a stuck PC
// (priority in that order) and keeps a PC history via pc_hist_buf.
module pc_run_monitor
    import pc_mon_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int CNT_WIDTH   = 16,
    parameter int NUM_HALT    = 2,
    parameter int HIST_DEPTH  = 8,
    parameter int STUCK_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    pc_run_monitor_if.slave   bus
);

    localparam int WHICH_W = clog2_min1(NUM_HALT);
    localparam int RL_W    = clog2_min1(STUCK_LIMIT + 1);
    localparam logic [RL_W-1:0] RL_MAX = RL_W'(STUCK_LIMIT);

    mon_state_t           state_q, state_nxt;
    logic [CNT_WIDTH-1:0] cyc_q, cyc_nxt, cyc_inc;
    logic [CNT_WIDTH-1:0] ret_q, ret_nxt, ret_inc;
    logic [RL_W-1:0]      rl_q, rl_nxt, rl_upd;
    logic [PC_WIDTH-1:0]  prev_pc_q, prev_pc_nxt;
    logic                 prev_vld_q, prev_vld_nxt;
    logic                 hit_q, hit_nxt;
    logic [WHICH_W-1:0]   which_q, which_nxt;
    logic                 to_q, to_nxt;
    logic                 stk_q, stk_nxt;
    logic                 hist_clr, hist_wr;

    logic                 halt_fire;
    logic [WHICH_W-1:0]   halt_idx;
    logic                 timeout_fire;
    logic                 stuck_fire;

    // Lowest enabled matching comparator wins.
    always_comb begin
        halt_fire = 1'b0;
        halt_idx  = '0;
        for (int unsigned i = 0; i < NUM_HALT; i++) begin
            if (!halt_fire && bus.pc_valid && bus.halt_en[i] &&
                bus.pc == bus.halt_pc[i*PC_WIDTH +: PC_WIDTH]) begin
                halt_fire = 1'b1;
                halt_idx  = WHICH_W'(i);
            end
        end
    end

    assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + CNT_WIDTH'(1);
    assign ret_inc = (ret_q == '1) ? ret_q : ret_q + CNT_WIDTH'(1);
    // The first retire after a clear has no predecessor and starts a new run.
    assign rl_upd  = (prev_vld_q && bus.pc == prev_pc_q) ?
                     ((rl_q >= RL_MAX) ? RL_MAX : rl_q + RL_W'(1)) : RL_W'(1);

    assign timeout_fire = (bus.max_cycles != '0) && (cyc_inc == bus.max_cycles);
    assign stuck_fire   = bus.pc_valid && (rl_upd == RL_MAX);

    always_comb begin
        state_nxt    = state_q;
        cyc_nxt      = cyc_q;
        ret_nxt      = ret_q;
        rl_nxt       = rl_q;
        prev_pc_nxt  = prev_pc_q;
        prev_vld_nxt = prev_vld_q;
        hit_nxt      = hit_q;
        which_nxt    = which_q;
        to_nxt       = to_q;
        stk_nxt      = stk_q;
        hist_clr     = 1'b0;
        hist_wr      = 1'b0;
        if (bus.start) begin
            // Start from IDLE, RUN or DONE shares one clear-and-run path.
            state_nxt    = MON_RUN;
            cyc_nxt      = '0;
            ret_nxt      = '0;
            rl_nxt       = '0;
            prev_pc_nxt  = '0;
            prev_vld_nxt = 1'b0;
            hit_nxt      = 1'b0;
            which_nxt    = '0;
            to_nxt       = 1'b0;
            stk_nxt      = 1'b0;
            hist_clr     = 1'b1;
        end else if (state_q == MON_RUN) begin
            cyc_nxt = cyc_inc;
            if (bus.pc_valid) begin
                ret_nxt      = ret_inc;
                rl_nxt       = rl_upd;
                prev_pc_nxt  = bus.pc;
                prev_vld_nxt = 1'b1;
                hist_wr      = 1'b1;
            end
            if (halt_fire) begin
                state_nxt = MON_DONE;
                hit_nxt   = 1'b1;
                which_nxt = halt_idx;
            end else if (timeout_fire) begin
                state_nxt = MON_DONE;
                to_nxt    = 1'b1;
            end else if (stuck_fire) begin
                state_nxt = MON_DONE;
                stk_nxt   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MON_IDLE;
            cyc_q      <= '0;
            ret_q      <= '0;
            rl_q       <= '0;
            prev_pc_q  <= '0;
            prev_vld_q <= 1'b0;
            hit_q      <= 1'b0;
            which_q    <= '0;
            to_q       <= 1'b0;
            stk_q      <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cyc_q      <= cyc_nxt;
            ret_q      <= ret_nxt;
            rl_q       <= rl_nxt;
            prev_pc_q  <= prev_pc_nxt;
            prev_vld_q <= prev_vld_nxt;
            hit_q      <= hit_nxt;
            which_q    <= which_nxt;
            to_q       <= to_nxt;
            stk_q      <= stk_nxt;
        end
    end

    pc_hist_buf #(
        .PC_WIDTH   (PC_WIDTH),
        .HIST_DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk     (clk),
        .rst     (rst),
        .clr     (hist_clr),
        .wr_en   (hist_wr),
        .wr_data (bus.pc),
        .rd_idx  (bus.hist_idx),
        .rd_data (bus.hist_pc)
    );

    assign bus.state      = state_q;
    assign bus.done       = (state_q == MON_DONE);
    assign bus.halt_hit   = hit_q;
    assign bus.halt_which = which_q;
    assign bus.timeout    = to_q;
    assign bus.stuck      = stk_q;
    assign bus.cycle_cnt  = cyc_q;
    assign bus.retire_cnt = ret_q;

endmodule

// File: tb/tb_pc_run_monitor.sv
// Scoreboard bench for pc_run_monitor: the stimulus side runs a
// list-based reference model and queues the expected post-edge status;
// an independent monitor pops and compares one entry per clock.
module tb_pc_run_monitor;

    localparam int PCW   = 32;
    localparam int CNTW  = 16;
    localparam int NH    = 2;
    localparam int HD    = 8;
    localparam int STUCK = 4;
    localparam int unsigned CMAX = 65535;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_run_monitor_if #(
        .PC_WIDTH   (PCW),
        .CNT_WIDTH  (CNTW),
        .NUM_HALT   (NH),
        .HIST_DEPTH (HD)
    ) bus ();

    pc_run_monitor #(
        .PC_WIDTH    (PCW),
        .CNT_WIDTH   (CNTW),
        .NUM_HALT    (NH),
        .HIST_DEPTH  (HD),
        .STUCK_LIMIT (STUCK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int unsigned st;
        bit          dn;
        bit          hh;
        int unsigned hw;
        bit          to;
        bit          sk;
        int unsigned cyc;
        int unsigned ret;
        logic [31:0] hp;
        bit          chk_hp;
    } exp_t;

    exp_t sbq[$];
    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: 0 idle, 1 run, 2 done; history is a plain list of
    // retired PCs since the last clear, newest at the back.
    int unsigned m_st, m_hw, m_cyc, m_ret;
    bit          m_hh, m_to, m_sk;
    logic [31:0] m_hist[$];

    function automatic void model_clear();
        m_hw = 0; m_cyc = 0; m_ret = 0;
        m_hh = 0; m_to = 0; m_sk = 0;
        m_hist.delete();
    endfunction

    // Number of identical PCs at the tail of the history, capped.
    function automatic int unsigned tail_run();
        int unsigned n, sz;
        sz = m_hist.size();
        n  = 1;
        while (n < STUCK && n < sz && m_hist[sz-1-n] == m_hist[sz-1]) n++;
        return n;
    endfunction

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s at %0t: got 0x%0h want 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic tick(input bit r, input bit s, input bit pv,
                        input logic [31:0] p, input int unsigned idx);
        exp_t e;
        bit   clr, hit;
        int unsigned which;
        rst = r;
        bus.start = s;
        bus.pc_valid = pv;
        bus.pc = p;
        bus.hist_idx = 3'(idx);
        clr = 0;
        e.hp = (idx < m_hist.size()) ? m_hist[m_hist.size()-1-idx] : 32'h0;
        if (r) begin
            model_clear();
            m_st = 0;
            e.hp = 32'h0;
        end else if (s) begin
            model_clear();
            m_st = 1;
            clr = 1;
        end else if (m_st == 1) begin
            m_cyc = (m_cyc < CMAX) ? m_cyc + 1 : CMAX;
            if (pv) begin
                m_ret = (m_ret < CMAX) ? m_ret + 1 : CMAX;
                m_hist.push_back(p);
                if (m_hist.size() > 64) void'(m_hist.pop_front());
            end
            hit = 0;
            which = 0;
            for (int i = 0; i < NH; i++) begin
                if (!hit && pv && bus.halt_en[i] && p == bus.halt_pc[i*PCW +: PCW]) begin
                    hit = 1;
                    which = i;
                end
            end
            if (hit) begin
                m_st = 2; m_hh = 1; m_hw = which;
            end else if (bus.max_cycles != 0 && m_cyc == int'(bus.max_cycles)) begin
                m_st = 2; m_to = 1;
            end else if (pv && tail_run() >= STUCK) begin
                m_st = 2; m_sk = 1;
            end
        end
        e.st = m_st; e.dn = (m_st == 2); e.hh = m_hh; e.hw = m_hw;
        e.to = m_to; e.sk = m_sk; e.cyc = m_cyc; e.ret = m_ret;
        e.chk_hp = !clr;
        sbq.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: one expected entry per clock edge, sampled 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("state",      bus.state,      e.st);
                chk("done",       bus.done,       e.dn);
                chk("halt_hit",   bus.halt_hit,   e.hh);
                chk("halt_which", bus.halt_which, e.hw);
                chk("timeout",    bus.timeout,    e.to);
                chk("stuck",      bus.stuck,      e.sk);
                chk("cycle_cnt",  bus.cycle_cnt,  e.cyc);
                chk("retire_cnt", bus.retire_cnt, e.ret);
                if (e.chk_hp) chk("hist_pc", bus.hist_pc, e.hp);
            end
        end
    end

    task automatic set_cfg(input logic [31:0] h0, input logic [31:0] h1,
                           input logic [1:0] en, input int unsigned mx);
        bus.halt_pc    = {h1, h0};
        bus.halt_en    = en;
        bus.max_cycles = 16'(mx);
    endtask

    initial begin
        logic [31:0] pool [4];
        logic [31:0] npc;
        pool[0] = 32'h40; pool[1] = 32'h44; pool[2] = 32'h48; pool[3] = 32'h200;
        bus.start = 0; bus.pc = 0; bus.pc_valid = 0; bus.hist_idx = 0;
        set_cfg(32'h0, 32'h0, 2'b00, 0);
        model_clear();
        m_st = 0;
        @(negedge clk);

        repeat (3) tick(1, 0, 0, 0, 0);

        // Halt at 0x118 after 71 retires
        set_cfg(32'h118, 32'hFFFF_FFF0, 2'b01, 0);
        tick(0, 1, 0, 0, 0);
        for (int k = 0; k <= 70; k++) tick(0, 0, 1, 32'(4 * k), $urandom_range(0, 7));
        repeat (3) tick(0, 0, 0, 0, $urandom_range(0, 7));

        // History wrap: 12 retires ending in a halt, then sweep the index
        set_cfg(32'h12C, 32'hFFFF_FFF0, 2'b01, 0);
        tick(0, 1, 0, 0, 0);
        for (int k = 0; k < 12; k++) tick(0, 0, 1, 32'h100 + 32'(4 * k), 0);
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 0, i);
        tick(0, 0, 0, 0, 7);

        // Timeout after 1000 cycles with gaps in pc_valid
        set_cfg(32'h0, 32'h0, 2'b00, 1000);
        npc = 32'h1000;
        tick(0, 1, 0, 0, 0);
        for (int k = 0; k < 1010; k++) begin
            if ($urandom_range(0, 3) != 0) begin
                tick(0, 0, 1, npc, $urandom_range(0, 7));
                npc += 4;
            end else begin
                tick(0, 0, 0, 32'hDEAD_BEEF, $urandom_range(0, 7));
            end
        end

        // Stuck PC, then the same with a halt on that PC, then halt+timeout
        set_cfg(32'h0, 32'h0, 2'b00, 0);
        tick(0, 1, 0, 0, 0);
        repeat (4) tick(0, 0, 1, 32'h40, 0);
        repeat (2) tick(0, 0, 0, 0, 1);
        set_cfg(32'h0, 32'h40, 2'b10, 0);
        tick(0, 1, 0, 0, 0);
        repeat (4) tick(0, 0, 1, 32'h40, 0);
        set_cfg(32'h200, 32'h0, 2'b01, 5);
        tick(0, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) tick(0, 0, 1, 32'h1F0 + 32'(4 * k), 0);
        repeat (2) tick(0, 0, 0, 0, 0);

        // Start in DONE clears everything
        tick(0, 1, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0, $urandom_range(0, 7));

        // Reset mid-run, then IDLE ignores pc_valid
        set_cfg(32'h0, 32'h0, 2'b00, 0);
        tick(0, 1, 0, 0, 0);
        for (int k = 0; k < 50; k++) tick(0, 0, 1'($urandom_range(0, 1)), 32'(8 * k), $urandom_range(0, 7));
        tick(1, 0, 0, 0, 0);
        repeat (2) tick(0, 0, 1, 32'h44, 0);

        // Restart while running
        tick(0, 1, 0, 0, 0);
        for (int k = 0; k < 10; k++) tick(0, 0, 1, 32'h300 + 32'(4 * k), $urandom_range(0, 7));
        tick(0, 1, 1, 32'h400, 0);
        for (int k = 0; k < 5; k++) tick(0, 0, 1, 32'h500 + 32'(4 * k), $urandom_range(0, 7));

        // Random mix of starts, resets, small PC pool and changing config
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 99) == 0)
                set_cfg(pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
                        2'($urandom_range(0, 3)),
                        ($urandom_range(0, 1) != 0) ? $urandom_range(1, 40) : 0);
            tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)],
                 $urandom_range(0, 7));
        end

        // No budget: cycle_cnt saturates and the run continues
        set_cfg(32'h0, 32'h0, 2'b00, 0);
        npc = 32'h8000_0000;
        tick(0, 1, 0, 0, 0);
        for (int k = 0; k < 70000; k++) begin
            if ($urandom_range(0, 3) != 0) begin
                tick(0, 0, 1, npc, $urandom_range(0, 7));
                npc += 4;
            end else begin
                tick(0, 0, 0, 0, $urandom_range(0, 7));
            end
        end

        repeat (2) @(negedge clk);
        if (sbq.size() != 0) chk("scoreboard_drain", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
